// File: rtl/decode_cycle.sv
// RV32I decode stage: instruction decode, immediate extension, 2R/1W register
// file with write-through bypass, and the ID/EX pipeline register.
module decode_cycle #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              InstrD,
  input  logic [XLEN-1:0]          PCD,
  input  logic [XLEN-1:0]          PCPlus4D,
  input  logic                     RegWriteW,
  input  logic [$clog2(NREGS)-1:0] RDW,
  input  logic [XLEN-1:0]          ResultW,
  input  logic                     FlushE,
  output logic                     RegWriteE,
  output logic [1:0]               ResultSrcE,
  output logic                     MemWriteE,
  output logic                     JumpE,
  output logic                     BranchE,
  output logic [2:0]               ALUControlE,
  output logic                     ALUSrcE,
  output logic [XLEN-1:0]          RD1E,
  output logic [XLEN-1:0]          RD2E,
  output logic [XLEN-1:0]          ImmExtE,
  output logic [$clog2(NREGS)-1:0] RS1E,
  output logic [$clog2(NREGS)-1:0] RS2E,
  output logic [$clog2(NREGS)-1:0] RDE,
  output logic [XLEN-1:0]          PCE,
  output logic [XLEN-1:0]          PCPlus4E
);

  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic [2:0]      alu_ctl;
    logic            alu_src;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } idex_t;

  logic [XLEN-1:0] regs_q [NREGS];
  idex_t           idex_d;
  idex_t           idex_q;

  logic [6:0]      opcode_c;
  logic [2:0]      funct3_c;
  logic            funct7b5_c;
  logic [AW-1:0]   rs1_c;
  logic [AW-1:0]   rs2_c;
  logic [AW-1:0]   rd_c;
  logic            wr_en_c;
  logic [XLEN-1:0] rd1_c;
  logic [XLEN-1:0] rd2_c;
  logic [XLEN-1:0] imm_i_c;
  logic [XLEN-1:0] imm_s_c;
  logic [XLEN-1:0] imm_b_c;
  logic [XLEN-1:0] imm_j_c;

  function automatic logic [2:0] alu_from_f3(input logic [2:0] f3, input logic sub);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign opcode_c   = InstrD[6:0];
  assign funct3_c   = InstrD[14:12];
  assign funct7b5_c = InstrD[30];
  assign rs1_c      = InstrD[15 +: AW];
  assign rs2_c      = InstrD[20 +: AW];
  assign rd_c       = InstrD[7 +: AW];

  assign imm_i_c = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  assign imm_s_c = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign imm_b_c = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign imm_j_c = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  assign wr_en_c = RegWriteW && (RDW != '0);

  // Register file: x0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[AW'(i)] <= '0;
      end
    end else if (wr_en_c) begin
      regs_q[RDW] <= ResultW;
    end
  end

  // Combinational read with write-through so a same-cycle writeback is seen.
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (rs1_c != '0) begin
      rd1_c = (wr_en_c && (RDW == rs1_c)) ? ResultW : regs_q[rs1_c];
    end
    if (rs2_c != '0) begin
      rd2_c = (wr_en_c && (RDW == rs2_c)) ? ResultW : regs_q[rs2_c];
    end
  end

  // Control decode; unknown opcodes leave every control bit low (bubble).
  always_comb begin
    idex_d          = '0;
    idex_d.rd1      = rd1_c;
    idex_d.rd2      = rd2_c;
    idex_d.rs1      = rs1_c;
    idex_d.rs2      = rs2_c;
    idex_d.rd       = rd_c;
    idex_d.pc       = PCD;
    idex_d.pc_plus4 = PCPlus4D;
    case (opcode_c)
      OP_LOAD: begin
        idex_d.reg_write  = 1'b1;
        idex_d.alu_src    = 1'b1;
        idex_d.result_src = RES_MEM;
        idex_d.imm        = imm_i_c;
        idex_d.alu_ctl    = ALU_ADD;
      end
      OP_STORE: begin
        idex_d.mem_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.imm       = imm_s_c;
        idex_d.alu_ctl   = ALU_ADD;
      end
      OP_RTYPE: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_ctl   = alu_from_f3(funct3_c, funct7b5_c);
      end
      OP_IALU: begin
        idex_d.reg_write = 1'b1;
        idex_d.alu_src   = 1'b1;
        idex_d.imm       = imm_i_c;
        idex_d.alu_ctl   = alu_from_f3(funct3_c, 1'b0);
      end
      OP_BEQ: begin
        idex_d.branch  = 1'b1;
        idex_d.imm     = imm_b_c;
        idex_d.alu_ctl = ALU_SUB;
      end
      OP_JAL: begin
        idex_d.jump       = 1'b1;
        idex_d.reg_write  = 1'b1;
        idex_d.result_src = RES_PC4;
        idex_d.imm        = imm_j_c;
        idex_d.alu_ctl    = ALU_ADD;
      end
      default: begin
        idex_d.result_src = RES_ALU;
      end
    endcase
  end

  // ID/EX register; a flush inserts the same all-zero bubble as reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_q <= '0;
    end else if (FlushE) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign RegWriteE   = idex_q.reg_write;
  assign ResultSrcE  = idex_q.result_src;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUControlE = idex_q.alu_ctl;
  assign ALUSrcE     = idex_q.alu_src;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign RS1E        = idex_q.rs1;
  assign RS2E        = idex_q.rs2;
  assign RDE         = idex_q.rd;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed, table-driven bench for the decode stage and its ID/EX register.
module tb_decode_cycle;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        j;
    logic        b;
    logic [2:0]  alu;
    logic        asrc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcp4;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rww;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic        flush;
    out_t        exp;
  } vec_t;

  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  int checks = 0;
  int errors = 0;
  out_t act;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always_comb act = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
                     ALUSrcE, RD1E, RD2E, ImmExtE, RS1E, RS2E, RDE, PCE, PCPlus4E};

  function automatic out_t e(input logic rw, input logic [1:0] rs, input logic mw,
                             input logic j, input logic b, input logic [2:0] alu,
                             input logic asrc, input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] pc);
    out_t o;
    o = '{rw, rs, mw, j, b, alu, asrc, rd1, rd2, imm, rs1, rs2, rd, pc, pc + 32'd4};
    return o;
  endfunction

  task automatic check(input string name, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    InstrD    = v.instr;
    PCD       = v.pc;
    PCPlus4D  = v.pc + 32'd4;
    RegWriteW = v.rww;
    RDW       = v.rdw;
    ResultW   = v.resw;
    FlushE    = v.flush;
  endtask

  initial begin
    // addi x1,x0,5 / lw / sw (bypass on rs2) / beq / jal
    vecs[0]  = '{32'h00500093, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 32'h0, 32'h0, 32'h5, 5'd0, 5'd5, 5'd1, 32'h100)};
    vecs[1]  = '{32'hFFC0A103, 32'h104, 1'b1, 5'd5, 32'hAAAA5555, 1'b0,
                 e(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd1, 5'd28, 5'd2, 32'h104)};
    vecs[2]  = '{32'h0021A423, 32'h108, 1'b1, 5'd2, 32'h0000BEEF, 1'b0,
                 e(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h0, 32'hBEEF, 32'h8, 5'd3, 5'd2, 5'd8, 32'h108)};
    vecs[3]  = '{32'hFE208CE3, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0, 32'hBEEF, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 32'h10C)};
    vecs[4]  = '{32'h0080006F, 32'h110, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h8, 5'd0, 5'd8, 5'd0, 32'h110)};
    // add x3,x1,x1 with same-cycle write of x1, then sub, then x0 write attempts
    vecs[5]  = '{32'h001081B3, 32'h114, 1'b1, 5'd1, 32'h12345678, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h12345678, 32'h12345678, 32'h0, 5'd1, 5'd1, 5'd3, 32'h114)};
    vecs[6]  = '{32'h40308233, 32'h118, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 32'h12345678, 32'h0, 32'h0, 5'd1, 5'd3, 5'd4, 32'h118)};
    vecs[7]  = '{32'h000001B3, 32'h11C, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd3, 32'h11C)};
    // I-ALU ignores funct7[5]; slt / ori / and / unmapped funct3
    vecs[8]  = '{32'h40000093, 32'h120, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 32'h0, 32'h0, 32'h400, 5'd0, 5'd0, 5'd1, 32'h120)};
    vecs[9]  = '{32'h0030A2B3, 32'h124, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b101, 1'b0, 32'h12345678, 32'h0, 32'h0, 5'd1, 5'd3, 5'd5, 32'h124)};
    vecs[10] = '{32'hFFF0E313, 32'h128, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 32'h12345678, 32'h0, 32'hFFFFFFFF, 5'd1, 5'd31, 5'd6, 32'h128)};
    vecs[11] = '{32'h0010F3B3, 32'h12C, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 32'h12345678, 32'h12345678, 32'h0, 5'd1, 5'd1, 5'd7, 32'h12C)};
    vecs[12] = '{32'h00109433, 32'h130, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h12345678, 32'h12345678, 32'h0, 5'd1, 5'd1, 5'd8, 32'h130)};
    // unknown opcode is a bubble with datapath fields intact
    vecs[13] = '{32'hFFC0A107, 32'h134, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h12345678, 32'h0, 32'h0, 5'd1, 5'd28, 5'd2, 32'h134)};
    // flush over a valid lw while x9 is written, then read x9 back
    vecs[14] = '{32'hFFC0A103, 32'h138, 1'b1, 5'd9, 32'h99, 1'b1, out_t'('0)};
    vecs[15] = '{32'h00048533, 32'h13C, 1'b0, 5'd0, 32'h0, 1'b0,
                 e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h99, 32'h0, 32'h0, 5'd9, 5'd0, 5'd10, 32'h13C)};

    rst = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", out_t'('0));

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b1;
      drive(vecs[i]);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset between edges clears outputs at once and wipes the register file
    #2 rst = 1'b0;
    #1 check("async_reset", out_t'('0));
    @(negedge clk);
    rst = 1'b1;
    drive('{32'h009085B3, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, out_t'('0)});
    @(posedge clk);
    #1 check("rf_cleared", e(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0,
                             5'd1, 5'd9, 5'd11, 32'h200));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
